picorv32_axi_ram: RTL
=====================

# picorv32_axi_ram

AXI4-lite responder (slave) that terminates the memory bus driven by the picodevice AXI adapter and backs it with a single-port, byte-writable on-chip RAM. It accepts the AW, W and AR channels independently and arbitrates one RAM access per cycle between the pending write and the pending read. It returns B and R responses with full backpressure support. It is the system RAM for simulation and FPGA builds of the multicore PicoRV32 device.

## Interface
- DEPTH, 4096: RAM size in 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH.
- INIT_FILE, "": hex file loaded into the RAM at elaboration (`$readmemh`); empty means no initialisation.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_axi_awvalid  in  1  write-address valid.
- mem_axi_awready  out  1  write-address ready.
- mem_axi_awaddr  in  32  write byte address.
- mem_axi_awprot  in  3  ignored.
- mem_axi_wvalid  in  1  write-data valid.
- mem_axi_wready  out  1  write-data ready.
- mem_axi_wdata  in  32  write data.
- mem_axi_wstrb  in  4  byte enables; bit n enables wdata[8n+7:8n].
- mem_axi_bvalid  out  1  write response valid.
- mem_axi_bready  in  1  write response ready.
- mem_axi_arvalid  in  1  read-address valid.
- mem_axi_arready  out  1  read-address ready.
- mem_axi_araddr  in  32  read byte address.
- mem_axi_arprot  in  3  ignored.
- mem_axi_rvalid  out  1  read data valid.
- mem_axi_rready  in  1  read data ready.
- mem_axi_rdata  out  32  read data.

## Operation
- **Word index:** word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored. The address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
- **Write holding registers:**
  - aw_full holds the captured address; w_full holds the captured data and strobes.
  - awready = ~aw_full and wready = ~w_full.
  - A handshake sets the corresponding full flag.
  - AW and W may arrive in either order or in the same cycle.
- **Write commit:**
  - The write is eligible when aw_full & w_full & ~bvalid.
  - On grant, the strobed bytes are written. Out-of-range writes are discarded silently, with no error response.
  - Both full flags are cleared and bvalid is set.
- **B channel:**
  - bvalid is held until bvalid & bready, then cleared.
  - New AW/W may be captured while bvalid is high, but they are not committed until B completes.
- **Read FSM:**
  - R_IDLE: arready=1. An AR handshake captures the address and moves to R_ACCESS.
  - R_ACCESS: arready=0; read eligible. On grant, rdata is registered from RAM (32'h0 if out of range) and the FSM moves to R_RESP.
  - R_RESP: rvalid=1 and rdata is held stable. An R handshake moves to R_IDLE.
- **Arbiter:**
  - When only one request is eligible, it is granted.
  - When both are eligible, the grant goes to the side not served last (prio bit). prio resets to read-first and toggles on every contended grant.
- **RAM contents:** not affected by reset.
- **Same-address read and write:** a read granted in the cycle after a write to the same word returns the new data. Read and write are never granted in the same cycle.

## Timing
- **Reset:** while reset is high:
  - awready, wready, arready, bvalid and rvalid are 0.
  - rdata is 32'h0.
  - Full flags are cleared, the FSM is in R_IDLE and prio=read.
- **After reset release:** in the first cycle after release, awready=wready=arready=1.
- **Reset mid-transaction:** all captured requests are dropped and no response is issued for them.
- **Write latency:** if AW and W complete at edge k and there is no contention, the RAM is written and bvalid rises at edge k+1. One lost arbitration adds 1 cycle.
- **Read latency:** if AR completes at edge k and there is no contention, rvalid rises at edge k+1 with valid rdata. One lost arbitration adds 1 cycle.
- **Throughput:**
  - Reads: back-to-back reads with rready held at 1 complete every 3 cycles (IDLE→ACCESS→RESP).
  - Writes: with bready=1, the next write can be captured in the cycle bvalid is high and commits one cycle after B completes.
- **Output stability:** all outputs are registered or derived only from registered state. There are no combinational paths from any input to any output.

## Test plan
- **Single write then read:**
  - Stimulus: AW=BASE+0x10 and W=32'hA5A5_1234 with strb=4'hF in the same cycle; then AR=BASE+0x10.
  - Required: bvalid 1 cycle after acceptance; rvalid 1 cycle after AR; rdata=32'hA5A5_1234.
- **Byte strobes and channel order:**
  - Stimulus: W (wdata=32'h1122_3344, strb=4'b0101) is presented 3 cycles before AW to a word preloaded with 32'hFFFF_FFFF.
  - Required: wready drops after W acceptance; write commits only once AW arrives; a later read returns 32'hFF22_FF44.
- **Contention:**
  - Stimulus: a write and a read become eligible in the same cycle, twice in a row.
  - Required: the first grant goes to the read (reset priority) and the second to the write; the write's bvalid is delayed by exactly 1 cycle.
- **Backpressure:**
  - Stimulus: bready=0 for 5 cycles while a second AW/W pair is presented; rready=0 for 4 cycles during a read.
  - Required: the second pair is captured but not committed until the B handshake; bvalid and rvalid stay high; rdata is held stable; arready=0 until the R handshake.
- **Out-of-range:**
  - Stimulus: write 32'hDEAD_BEEF to BASE+4*DEPTH, then read BASE+4*DEPTH and BASE+0.
  - Required: a B response is issued; the out-of-range read returns 32'h0; word 0 is unchanged.
- **Reset mid-operation:**
  - Stimulus: assert reset while in R_RESP with a captured AW pending.
  - Required: rvalid and bvalid go to 0 immediately (asynchronously); readys return to 1 one cycle after release; no stray B or R response follows; previously written RAM data is still readable.

Source files
------------

// File: rtl/picorv32_axi_ram.sv
// -----------------------------------------------------------------------------
// picorv32_axi_ram
//
// AXI4-lite responder backed by a single-port, byte-writable on-chip RAM.
// The AW, W and AR channels are captured independently into holding
// registers; an arbiter grants at most one RAM access (write or read) per
// cycle. B and R responses are held until the manager accepts them.
//
// Parameters:
//   DEPTH      RAM size in 32-bit words (power of two, >= 2)
//   BASE_ADDR  byte address of word 0, aligned to 4*DEPTH
//   INIT_FILE  optional hex image name
//
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   mem_axi_aw{valid,ready,addr,prot}  write address channel (prot ignored)
//   mem_axi_w{valid,ready,data,strb}   write data channel
//   mem_axi_b{valid,ready}             write response channel
//   mem_axi_ar{valid,ready,addr,prot}  read address channel (prot ignored)
//   mem_axi_r{valid,ready,data}        read data channel
//
// Every output comes straight from a register or from registered state only.
// -----------------------------------------------------------------------------
module picorv32_axi_ram #(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter              INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,

   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,

   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,

   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,

   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [31:0] SPAN  = 32'(DEPTH) << 2;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ACCESS,
      R_RESP
   } r_state_t;

   // RAM array
   logic [31:0] mem [DEPTH];

   // Holds the readys low during reset and for the edge that ends it.
   logic ready_q;

   // Write holding registers
   logic        aw_full;
   logic        w_full;
   logic [31:0] aw_addr_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        b_valid_q;

   // Read side
   r_state_t    r_state;
   logic [31:0] ar_addr_q;
   logic        ar_ready_q;
   logic        r_valid_q;
   logic [31:0] r_data_q;

   // Arbitration: prio_wr=1 means the write wins the next contended cycle.
   logic        prio_wr;
   logic        wr_elig;
   logic        rd_elig;
   logic        grant_wr;
   logic        grant_rd;

   // Address decode. The subtraction wraps for addresses below BASE_ADDR, so
   // a single unsigned compare covers both ends of the window.
   logic [31:0]      wr_off;
   logic [31:0]      rd_off;
   logic             wr_in_range;
   logic             rd_in_range;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   assign wr_off      = aw_addr_q - BASE_ADDR;
   assign rd_off      = ar_addr_q - BASE_ADDR;
   assign wr_in_range = (wr_off < SPAN);
   assign rd_in_range = (rd_off < SPAN);
   assign wr_idx      = wr_off[IDX_W+1:2];
   assign rd_idx      = rd_off[IDX_W+1:2];

   // Protection attributes carry no meaning for this RAM.
   logic unused_prot;
   assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

   assign mem_axi_awready = ready_q & ~aw_full;
   assign mem_axi_wready  = ready_q & ~w_full;
   assign mem_axi_bvalid  = b_valid_q;
   assign mem_axi_arready = ar_ready_q;
   assign mem_axi_rvalid  = r_valid_q;
   assign mem_axi_rdata   = r_data_q;

   // A write may not commit while its predecessor's B response is pending.
   assign wr_elig = aw_full & w_full & ~b_valid_q;
   assign rd_elig = (r_state == R_ACCESS);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through it can leave a value unassigned and infer a latch.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (wr_elig && rd_elig) begin
         grant_wr = prio_wr;
         grant_rd = ~prio_wr;
      end else begin
         grant_wr = wr_elig;
         grant_rd = rd_elig;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q <= 1'b0;
         prio_wr <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (wr_elig && rd_elig) begin
            prio_wr <= ~prio_wr;
         end
      end
   end

   // Write holding registers and B channel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid_q <= 1'b0;
      end else begin
         if (mem_axi_awvalid && mem_axi_awready) begin
            aw_full   <= 1'b1;
            aw_addr_q <= mem_axi_awaddr;
         end
         if (mem_axi_wvalid && mem_axi_wready) begin
            w_full   <= 1'b1;
            w_data_q <= mem_axi_wdata;
            w_strb_q <= mem_axi_wstrb;
         end
         // A grant needs both flags set, so it never collides with a capture.
         if (grant_wr) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            b_valid_q <= 1'b1;
         end else if (b_valid_q && mem_axi_bready) begin
            b_valid_q <= 1'b0;
         end
      end
   end

   // NOTE: the RAM array has no reset; its contents survive reset and it maps
   // onto block RAM only when left unreset.
   always_ff @(posedge clk) begin
      if (grant_wr && wr_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) begin
               mem[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
            end
         end
      end
   end

   // Read FSM with registered arready/rvalid/rdata
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= R_IDLE;
         ar_addr_q  <= '0;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_data_q   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               ar_ready_q <= 1'b1;
               if (mem_axi_arvalid && ar_ready_q) begin
                  ar_addr_q  <= mem_axi_araddr;
                  ar_ready_q <= 1'b0;
                  r_state    <= R_ACCESS;
               end
            end
            R_ACCESS: begin
               if (grant_rd) begin
                  r_data_q  <= rd_in_range ? mem[rd_idx] : 32'h0;
                  r_valid_q <= 1'b1;
                  r_state   <= R_RESP;
               end
            end
            R_RESP: begin
               if (mem_axi_rready) begin
                  r_valid_q  <= 1'b0;
                  ar_ready_q <= 1'b1;
                  r_state    <= R_IDLE;
               end
            end
            default: begin
               r_state <= R_IDLE;
            end
         endcase
      end
   end

endmodule
